// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and the slave memory map.
// The command struct carries APB_ADDR_W address bits, so the bridge keeps ADDR_W at this width.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_ADDR_W-1:0] APB_WORD0_ADDR = 8'h00;
  localparam logic [APB_ADDR_W-1:0] APB_WORD1_ADDR = 8'h04;
  localparam logic [APB_ADDR_W-1:0] APB_WORD2_ADDR = 8'h08;
  localparam logic [APB_ADDR_W-1:0] APB_WORD3_ADDR = 8'h0C;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into single APB3 SETUP/ACCESS transfers and
// returns one response per command; misaligned addresses are rejected without a bus cycle.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e       state_q, state_d;
  apb_cmd_t         cmd_q, cmd_d;
  apb_rsp_t         rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_fire;
  logic             timed_out;

  // Held low while PRESET is asserted so no command is accepted in the reset cycle.
  assign cmd_ready = (state_q == IDLE) && !PRESET;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign timed_out = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          cmd_d = '{write: cmd_write, addr: APB_ADDR_W'(cmd_addr), wdata: cmd_wdata};
          if (cmd_addr[1:0] != 2'b00) begin
            rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the last allowed cycle beats the timeout.
        if (PREADY) begin
          rsp_d   = '{rdata: (cmd_q.write || PSLVERR) ? '0 : PRDATA, err: PSLVERR, timeout: 1'b0};
          cnt_d   = '0;
          state_d = RESP;
        end else if (timed_out) begin
          rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (PRESET) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = cmd_q.write;
  assign PADDR       = ADDR_W'(cmd_q.addr);
  assign PWDATA      = cmd_q.wdata;

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a registered-PREADY four-word slave model, a vector
// table of single commands, and hand-written backpressure and mid-transfer reset sequences.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  // Slave model: four words at 0..12, PSLVERR at 16 and above, registered PREADY,
  // PRDATA carries junk whenever no read data is being returned.
  logic [31:0] mem [4];
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= GARBAGE;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= GARBAGE;
      if (PSEL && PENABLE && !PREADY && !stall) begin
        PREADY <= 1'b1;
        if (PADDR >= 8'd16)  PSLVERR <= 1'b1;
        else if (PWRITE)     mem[PADDR[3:2]] <= PWDATA;
        else                 PRDATA <= mem[PADDR[3:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 with the bridge idle; returns at posedge+1 after the first rsp_valid cycle.
  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output logic err, output logic to,
                         output int hs_wait, output int lat, output int n_setup,
                         output int n_access, output int bus_bad);
    logic fire, got;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    hs_wait = 0; lat = 1; n_setup = 0; n_access = 0; bus_bad = 0;
    rdata = '0; err = 1'b0; to = 1'b0; fire = 1'b0; got = 1'b0;
    while (!fire && hs_wait < 64) begin
      @(negedge PCLK);
      fire = cmd_ready;
      @(posedge PCLK); #1;
      if (!fire) hs_wait++;
    end
    cmd_valid = 1'b0;
    while (!got && lat < 64) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) n_setup++;
      if (PSEL && PENABLE)  n_access++;
      if (PSEL && (PADDR !== a || PWRITE !== w || PWDATA !== d)) bus_bad++;
      if (rsp_valid) begin
        got = 1'b1; rdata = rsp_rdata; err = rsp_err; to = rsp_timeout;
      end
      @(posedge PCLK); #1;
      if (!got) lat++;
    end
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
    int          exp_setup;
    int          exp_access;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata;
    logic        err, to;
    int          hs_wait, lat, n_setup, n_access, bus_bad, seen;

    vecs[0]  = '{1'b1, APB_WORD1_ADDR, 32'hA5A5_1234, 1'b0, 32'h0,          1'b0, 1'b0, 4,  1, 2};
    vecs[1]  = '{1'b0, APB_WORD1_ADDR, 32'h0,         1'b0, 32'hA5A5_1234, 1'b0, 1'b0, 4,  1, 2};
    vecs[2]  = '{1'b1, 8'h06,          32'hCAFE_F00D, 1'b0, 32'h0,          1'b1, 1'b0, 1,  0, 0};
    vecs[3]  = '{1'b1, 8'h10,          32'h1234_5678, 1'b0, 32'h0,          1'b1, 1'b0, 4,  1, 2};
    vecs[4]  = '{1'b1, APB_WORD2_ADDR, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b0, 1'b0, 4,  1, 2};
    vecs[5]  = '{1'b0, APB_WORD2_ADDR, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4,  1, 2};
    vecs[6]  = '{1'b0, 8'h11,          32'h0,         1'b0, 32'h0,          1'b1, 1'b0, 1,  0, 0};
    vecs[7]  = '{1'b0, 8'h14,          32'h0,         1'b0, 32'h0,          1'b1, 1'b0, 4,  1, 2};
    vecs[8]  = '{1'b1, APB_WORD3_ADDR, 32'h55AA_55AA, 1'b1, 32'h0,          1'b1, 1'b1, 18, 1, 16};
    vecs[9]  = '{1'b0, APB_WORD3_ADDR, 32'h0,         1'b0, 32'h0,          1'b0, 1'b0, 4,  1, 2};
    vecs[10] = '{1'b0, APB_WORD0_ADDR, 32'h0,         1'b1, 32'h0,          1'b1, 1'b1, 18, 1, 16};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; stall = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    @(negedge PCLK);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    check("rst_psel_penable_pwrite", {29'b0, PSEL, PENABLE, PWRITE}, 32'h0);
    check("rst_paddr", {24'b0, PADDR}, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rsp_flags", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    @(posedge PCLK); #1;

    for (int i = 0; i < 11; i++) begin
      stall = vecs[i].stall;
      run_cmd(vecs[i].w, vecs[i].addr, vecs[i].wdata, rdata, err, to,
              hs_wait, lat, n_setup, n_access, bus_bad);
      check($sformatf("v%0d_hs_wait", i), hs_wait, 0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_setup_cycles", i), n_setup, vecs[i].exp_setup);
      check($sformatf("v%0d_access_cycles", i), n_access, vecs[i].exp_access);
      check($sformatf("v%0d_bus_stable", i), bus_bad, 0);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_timeout", i), {31'b0, to}, {31'b0, vecs[i].exp_to});
    end
    stall = 1'b0;

    // Backpressure: response for a read of word 2 is held while a new command waits.
    rsp_ready = 1'b0;
    run_cmd(1'b0, APB_WORD2_ADDR, 32'h0, rdata, err, to, hs_wait, lat, n_setup, n_access, bus_bad);
    check("bp_latency", lat, 4);
    check("bp_rdata", rdata, 32'hDEAD_BEEF);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = APB_WORD0_ADDR; cmd_wdata = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      check($sformatf("bp_hold%0d_valid_ready_psel", i), {29'b0, rsp_valid, cmd_ready, PSEL}, 32'h4);
      check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'hDEAD_BEEF);
      @(posedge PCLK); #1;
    end
    rsp_ready = 1'b1;
    run_cmd(1'b1, APB_WORD0_ADDR, 32'h1111_2222, rdata, err, to, hs_wait, lat, n_setup, n_access, bus_bad);
    check("bp_pending_hs_wait", hs_wait, 1);
    check("bp_pending_err", {31'b0, err}, 32'h0);
    run_cmd(1'b0, APB_WORD0_ADDR, 32'h0, rdata, err, to, hs_wait, lat, n_setup, n_access, bus_bad);
    check("bp_readback", rdata, 32'h1111_2222);

    // Reset pulse during the ACCESS phase of a stalled write.
    stall = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = APB_WORD3_ADDR; cmd_wdata = 32'h7777_0001;
    @(negedge PCLK);
    check("rp_accept", {31'b0, cmd_ready}, 32'h1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge PCLK); #1; end
    @(negedge PCLK);
    check("rp_in_access", {30'b0, PSEL, PENABLE}, 32'h3);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rp_cmd_ready_in_reset", {31'b0, cmd_ready}, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rp_bus_idle", {30'b0, PSEL, PENABLE}, 32'h0);
    check("rp_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rp_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      if (rsp_valid || PSEL) seen++;
    end
    check("rp_no_response", seen, 0);
    @(posedge PCLK); #1;
    stall = 1'b0;
    run_cmd(1'b0, APB_WORD3_ADDR, 32'h0, rdata, err, to, hs_wait, lat, n_setup, n_access, bus_bad);
    check("rp_after_latency", lat, 4);
    check("rp_after_rdata", rdata, 32'h0);
    check("rp_after_err", {31'b0, err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
